// File: rtl/timer_pkg.sv
// Shared definitions for the timer family: state encoding and default width.
package timer_pkg;

  // Matches the prescaler divider width.
  localparam int TIMER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/edge_detect_rise.sv
// Single-cycle pulse on each rising edge of a signal already registered in the clk domain.
// The history register resets to 1, so an input that is high as reset releases
// does not produce a pulse until it falls and rises again.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_d;

  // Delayed copy of the input, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (rst) in_d <= 1'b1;
    else     in_d <= in;
  end

  assign pulse = in & ~in_d;

endmodule

// File: rtl/pwm_timer.sv
// PWM timer driven by rising edges of the prescaler slow_clk.
// Up-counter 0..period_sh with shadowed period/compare (reloaded only at wrap
// or on arming), a registered PWM output, a sticky overflow flag and an
// optional one-shot mode that parks in DONE until en is dropped.
module pwm_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             en,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] compare,
  input  logic             pol,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             pwm_out,
  output logic             ovf_flag,
  output logic             busy
);

  timer_state_e     state;
  timer_state_e     state_next;
  logic             tick;
  logic             wrap;
  logic             ovf_set;
  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] compare_sh;

  edge_detect_rise u_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (slow_clk),
    .pulse (tick)
  );

  // A wrap only counts while running and still enabled; dropping en wins.
  assign wrap    = tick & (count == period_sh);
  assign ovf_set = (state == RUN) & en & wrap;
  assign busy    = (state == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN: begin
        if (!en)                  state_next = IDLE;
        else if (wrap && one_shot) state_next = DONE;
      end
      DONE: if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter and shadow registers; shadows load on arming and on every wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      period_sh  <= '0;
      compare_sh <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!en) begin
            count <= '0;
          end else if (wrap) begin
            count      <= '0;
            period_sh  <= period;
            compare_sh <= compare;
          end else if (tick) begin
            count <= count + WIDTH'(1);
          end
        end
        IDLE: begin
          count <= '0;
          if (en) begin
            period_sh  <= period;
            compare_sh <= compare;
          end
        end
        default: count <= '0;
      endcase
    end
  end

  // Sticky overflow flag: a set on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)          ovf_flag <= 1'b0;
    else if (ovf_set) ovf_flag <= 1'b1;
    else if (irq_clr) ovf_flag <= 1'b0;
  end

  // Registered PWM compare; outside RUN it rests at the inactive level (pol).
  always_ff @(posedge clk) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= ((state == RUN) & (count < compare_sh)) ^ pol;
  end

endmodule

// File: doc/pwm_timer.md
Name: pwm_timer

Overview:
- Downstream consumer of the prescaler's `slow_clk` output.
- Converts each rising edge of `slow_clk` into a single-cycle count enable in the `clk` domain.
- Drives a WIDTH-bit up-counter with programmable period and compare values.
- Produces a PWM output, an overflow (update) flag for interrupt logic, and a live count for register readback. Supports continuous and one-shot modes.

Parameters:
- WIDTH, 16, width of counter, period and compare. Matches the prescaler `div` width.

Ports:
- clk  input  1  system clock; the same clock that drives the prescaler.
- rst  input  1  synchronous reset, active-high.
- slow_clk  input  1  prescaler output. Registered in the `clk` domain, so no synchroniser is needed.
- en  input  1  timer enable (level).
- one_shot  input  1  1 = stop after first wrap; 0 = continuous.
- period  input  WIDTH  auto-reload value; counter range is 0..period.
- compare  input  WIDTH  PWM duty threshold.
- pol  input  1  output polarity; 1 inverts `pwm_out`.
- irq_clr  input  1  single-cycle clear of `ovf_flag`.
- count  output  WIDTH  current counter value.
- pwm_out  output  1  registered PWM output.
- ovf_flag  output  1  sticky overflow/update flag.
- busy  output  1  high while in state RUN.

Behaviour:
- Reset: on `posedge clk` with `rst`=1:
  - state=IDLE; count=0; period_sh=0; compare_sh=0.
  - ovf_flag=0; pwm_out=0; busy=0.
  - slow_clk_d=1, so a high `slow_clk` at reset release gives no tick.
  - Reset in mid-run aborts immediately, with no ovf.
- Tick: tick = slow_clk & ~slow_clk_d (combinational). `slow_clk_d` is registered every cycle. Exactly one tick per `slow_clk` rising edge.
- State IDLE:
  - count=0, busy=0; ticks are ignored.
  - en=1 -> RUN. On the same edge, load period_sh<=period and compare_sh<=compare.
  - A tick in the transition cycle is ignored.
- State RUN (busy=1), on a tick:
  - If count==period_sh (wrap):
    - count<=0; ovf_flag<=1.
    - Reload period_sh<=period and compare_sh<=compare.
    - If one_shot=1 -> DONE.
  - Otherwise count<=count+1.
  - Without a tick, count holds.
  - en=0 -> IDLE next edge, with count<=0. Takes priority over a simultaneous tick/wrap; no ovf is set on that edge.
- State DONE:
  - count=0, busy=0; ticks are ignored.
  - Stays in DONE until en=0, then -> IDLE. Re-arming requires en to go low then high.
- Shadowing: writes to `period`/`compare` while in RUN take effect only at the next wrap, never mid-period.
- Period 0: every tick is a wrap, so ovf sets on every tick.
- PWM:
  - pwm_out <= ((state==RUN) & (count < compare_sh)) ^ pol.
  - Registered, so it lags `count` by one clk.
  - compare_sh=0 -> always inactive. compare_sh > period_sh -> always active (100%).
  - In IDLE/DONE, pwm_out=pol (inactive level). The reset value is 0 regardless of pol.
- ovf_flag:
  - Set on a wrap; cleared by irq_clr.
  - A set and a clear on the same edge -> set wins.
  - The flag is not cleared by en=0.
- Latency: slow_clk rises at edge n -> count updates at edge n+1 -> pwm_out reflects the new count at edge n+2.
- Arithmetic: unsigned WIDTH-bit. The counter never exceeds period_sh, so there is no natural rollover. period=2^WIDTH-1 is legal.

Decomposition:
- Shared package (timer_pkg):
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default WIDTH=16, shared with the prescaler `div` width.
- One sub-module: edge_detect_rise (clk, rst, in -> pulse), with its register reset to 1. It is reusable by the capture/input blocks.
- Counter, FSM and PWM compare stay in pwm_timer.

Test Plan:
1. Basic PWM: period=9, compare=3, pol=0, en=1, slow_clk toggled every 4 clk -> pwm high for 3 of every 10 ticks, count cycles 0..9, ovf_flag set on the 9->0 wrap.
2. Shadow reload: mid-run write period=4, compare=2 at count=5 (old period=9) -> count continues to 9, then wraps to 0 and runs 0..4; duty becomes 2/5 only after the wrap.
3. One-shot: one_shot=1, period=3 -> count 0,1,2,3,0, then state DONE, busy=0, pwm=pol, ovf=1. Further slow_clk edges leave count=0. en 0->1 restarts.
4. Edge cases: compare=0 -> pwm constant 0; compare=20 with period=9 -> pwm constant 1; period=0 -> ovf sets on every tick; pol=1 inverts all of these.
5. Simultaneous: irq_clr on the same clk as a wrap -> ovf_flag stays 1. en=0 on the same clk as a wrap tick -> count=0, state IDLE, ovf unchanged.
6. Reset: assert rst for 1 clk at count=6 with slow_clk high -> next cycle all outputs 0, state IDLE, and no tick from the held-high slow_clk until it falls and rises again.
